// File: rtl/msg_expand_if.sv
// Handshake bundle between the SM3 message expander and its block source / round consumer.
interface msg_expand_if;
    logic         load;
    logic [511:0] din;
    logic         load_ready;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  wj;
    logic [31:0]  wpj;
    logic [5:0]   jidx;
    logic         done;

    modport slave (
        input  load, din, w_ready,
        output load_ready, w_valid, wj, wpj, jidx, done
    );

    modport master (
        output load, din, w_ready,
        input  load_ready, w_valid, wj, wpj, jidx, done
    );
endinterface

// File: rtl/msg_expand.sv
// SM3 message expansion: streams (W_j, W_j ^ W_{j+4}) for j=0..63 from a 16-word sliding window.
module modulep1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = x ^ {x[16:0], x[31:17]} ^ {x[8:0], x[31:9]};
endmodule

module msg_expand (
    input  logic         clk,
    input  logic         rst,
    msg_expand_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [5:0]  j;
    logic        done_q;

    logic        accept;
    logic        xfer;
    logic        last;
    logic [31:0] p1_in;
    logic [31:0] p1_out;
    logic [31:0] w_new;

    assign accept = (state == IDLE) && bus.load;
    assign xfer   = (state == RUN) && bus.w_ready;
    assign last   = xfer && (j == 6'd63);

    // win[0]=W_{j}, so W_{j+16} draws on W_j, W_{j+7}, W_{j+13}, W_{j+3}, W_{j+10}
    assign p1_in = win[0] ^ win[7] ^ {win[13][16:0], win[13][31:17]};
    assign w_new = p1_out ^ {win[3][24:0], win[3][31:25]} ^ win[10];

    modulep1 u_p1 (
        .x (p1_in),
        .y (p1_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (bus.load) begin
                state_next = RUN;
            end
        end else begin
            if (last) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 16; k++) begin
                win[k] <= '0;
            end
            j      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                for (int unsigned k = 0; k < 16; k++) begin
                    win[k] <= bus.din[511 - 32*k -: 32];
                end
                j <= '0;
            end else if (xfer) begin
                for (int unsigned k = 0; k < 15; k++) begin
                    win[k] <= win[k+1];
                end
                win[15] <= w_new;
                j       <= j + 6'd1;
            end
        end
    end

    assign bus.wj         = win[0];
    assign bus.wpj        = win[0] ^ win[4];
    assign bus.jidx       = j;
    assign bus.w_valid    = (state == RUN);
    assign bus.load_ready = (state == IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_msg_expand.sv
// Directed and randomised bench for msg_expand against an array-form SM3 expansion model.
module tb_msg_expand;
    logic clk = 1'b0;
    logic rst;
    msg_expand_if bus ();

    msg_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0]  w [68];
    logic [31:0]  obs_wj [64];
    logic [31:0]  obs_wpj [64];
    logic [511:0] abc_blk;
    logic [511:0] other_blk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic expand(input logic [511:0] b);
        logic [31:0] x;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            x = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w[i-13], 7) ^ w[i-6];
        end
    endtask

    // Called just after a negedge with the DUT idle; returns at the negedge of cycle t+1.
    task automatic load_block(input logic [511:0] b);
        checks++;
        if (bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_before_load got=%b want=1", bus.load_ready);
        end
        bus.load = 1'b1;
        bus.din  = b;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Consumes one full stream; returns at the negedge of the done cycle.
    task automatic stream(input bit stall, input int inject_at, input logic [511:0] junk);
        int k = 0;
        int cyc = 0;
        bit r;
        while (k < 64 && cyc < 400) begin
            checks++;
            if (bus.w_valid !== 1'b1 || bus.jidx !== 6'(k)) begin
                errors++;
                $display("FAIL stream_idx got valid=%b jidx=%0d want valid=1 jidx=%0d", bus.w_valid, bus.jidx, k);
            end
            checks++;
            if (bus.wj !== w[k]) begin
                errors++;
                $display("FAIL stream_wj j=%0d got=%08h want=%08h", k, bus.wj, w[k]);
            end
            checks++;
            if (bus.wpj !== (w[k] ^ w[k+4])) begin
                errors++;
                $display("FAIL stream_wpj j=%0d got=%08h want=%08h", k, bus.wpj, w[k] ^ w[k+4]);
            end
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL stream_done_early j=%0d got=%b want=0", k, bus.done);
            end
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.w_ready = r;
            bus.load    = (k == inject_at);
            if (k == inject_at) bus.din = junk;
            if (r) begin
                obs_wj[k]  = bus.wj;
                obs_wpj[k] = bus.wpj;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.load = 1'b0;
        if (k < 64) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout got=%0d transfers want=64", k);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.load_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got done=%b load_ready=%b w_valid=%b want 1 1 0",
                     bus.done, bus.load_ready, bus.w_valid);
        end
    endtask

    task automatic check_done_cleared(input string tag);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.load_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done got done=%b load_ready=%b w_valid=%b want 0 1 0",
                     tag, bus.done, bus.load_ready, bus.w_valid);
        end
    endtask

    task automatic test_reset;
        bus.load = 1'b0;
        bus.din = '0;
        bus.w_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.w_valid !== 1'b0 || bus.load_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b ready=%b done=%b want 0 1 0",
                     bus.w_valid, bus.load_ready, bus.done);
        end
        checks++;
        if (bus.wj !== 32'h0 || bus.wpj !== 32'h0 || bus.jidx !== 6'd0) begin
            errors++;
            $display("FAIL reset_data got wj=%08h wpj=%08h jidx=%0d want 0 0 0", bus.wj, bus.wpj, bus.jidx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abc;
        expand(abc_blk);
        load_block(abc_blk);
        stream(1'b0, -1, '0);
        checks++;
        if (obs_wj[0] !== 32'h61626380 || obs_wpj[0] !== 32'h61626380) begin
            errors++;
            $display("FAIL abc_j0 got wj=%08h wpj=%08h want 61626380 61626380", obs_wj[0], obs_wpj[0]);
        end
        checks++;
        if (obs_wpj[12] !== 32'h9092E200) begin
            errors++;
            $display("FAIL abc_wpj12 got=%08h want=9092e200", obs_wpj[12]);
        end
        checks++;
        if (obs_wj[16] !== 32'h9092E200) begin
            errors++;
            $display("FAIL abc_wj16 got=%08h want=9092e200", obs_wj[16]);
        end
        check_done_cleared("abc");
    endtask

    task automatic test_stall;
        expand(abc_blk);
        load_block(abc_blk);
        stream(1'b1, -1, '0);
        check_done_cleared("stall");
    endtask

    task automatic test_load_ignored;
        expand(abc_blk);
        load_block(abc_blk);
        stream(1'b0, 20, other_blk);
        check_done_cleared("load_ignored");
    endtask

    task automatic test_async_reset;
        expand(abc_blk);
        load_block(abc_blk);
        bus.w_ready = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge clk);
        checks++;
        if (bus.jidx !== 6'd30 || bus.wj !== w[30]) begin
            errors++;
            $display("FAIL areset_pre got jidx=%0d wj=%08h want 30 %08h", bus.jidx, bus.wj, w[30]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.jidx !== 6'd0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ctrl got valid=%b jidx=%0d ready=%b want 0 0 1",
                     bus.w_valid, bus.jidx, bus.load_ready);
        end
        checks++;
        if (bus.wj !== 32'h0 || bus.wpj !== 32'h0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL areset_data got wj=%08h wpj=%08h done=%b want 0 0 0", bus.wj, bus.wpj, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        load_block(abc_blk);
        stream(1'b0, -1, '0);
        check_done_cleared("areset");
    endtask

    task automatic test_back_to_back;
        expand(abc_blk);
        load_block(abc_blk);
        stream(1'b0, -1, '0);
        expand(other_blk);
        load_block(other_blk);
        stream(1'b0, -1, '0);
        check_done_cleared("b2b");
    endtask

    task automatic test_random;
        logic [511:0] b;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
            expand(b);
            load_block(b);
            stream(n[0], -1, '0);
            check_done_cleared("random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;
        other_blk = {16{32'hDEADBEEF}};
        test_reset();
        test_abc();
        test_stall();
        test_load_ignored();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
